// File: rtl/booth4_mul_if.sv
// Request/response bundle for the radix-4 Booth multiplier: issue side with
// operands and flush, result side with valid/ready backpressure.
interface booth4_mul_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            mul_valid;
  logic            mul_ready;
  logic            a_signed;
  logic            b_signed;
  logic            mul_word;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output flush, mul_valid, a_signed, b_signed, mul_word,
           multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  flush, mul_valid, a_signed, b_signed, mul_word,
           multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/booth4_mul_unit.sv
// Iterative radix-4 Booth multiplier (signed/unsigned/mixed, optional 32-bit
// word mode) with one Booth digit retired per cycle and early termination.
module booth4_mul_unit #(
  parameter int XLEN       = 64,
  parameter bit WORD_EN    = 1'b1,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  booth4_mul_if.slave  bus
);
  localparam int W       = XLEN + 2;
  localparam int N       = W / 2;
  localparam int CW      = $clog2(N + 1);
  localparam bit WORD_OK = WORD_EN && (XLEN >= 64);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W:0]      mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;

  logic [W-1:0]    ext_a, ext_b;
  logic [2*W-1:0]  pp;
  logic            pp_neg;
  logic [2*W-1:0]  sum;
  logic [W:0]      mplier_shift;
  logic            last_step;
  logic [XLEN-1:0] res_hi, res_lo;

  // Operand extension and result formatting differ only when word mode exists.
  if (WORD_OK) begin : g_word
    always_comb begin
      if (bus.mul_word) begin
        ext_a = {{(W-32){bus.a_signed & bus.multiplicand[31]}}, bus.multiplicand[31:0]};
        ext_b = {{(W-32){bus.b_signed & bus.multiplier[31]}}, bus.multiplier[31:0]};
      end else begin
        ext_a = {{2{bus.a_signed & bus.multiplicand[XLEN-1]}}, bus.multiplicand};
        ext_b = {{2{bus.b_signed & bus.multiplier[XLEN-1]}}, bus.multiplier};
      end
    end
    assign res_lo = word_q ? {{(XLEN-32){sum[31]}}, sum[31:0]}  : sum[XLEN-1:0];
    assign res_hi = word_q ? {{(XLEN-32){sum[63]}}, sum[63:32]} : sum[2*XLEN-1:XLEN];
  end else begin : g_noword
    assign ext_a  = {{2{bus.a_signed & bus.multiplicand[XLEN-1]}}, bus.multiplicand};
    assign ext_b  = {{2{bus.b_signed & bus.multiplier[XLEN-1]}}, bus.multiplier};
    assign res_lo = sum[XLEN-1:0];
    assign res_hi = sum[2*XLEN-1:XLEN];
  end

  // Booth digit from the overlapping 3-bit window; negatives use ~x + 1.
  always_comb begin
    pp     = '0;
    pp_neg = 1'b0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100: begin
        pp     = ~(mcand_q << 1);
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp     = ~mcand_q;
        pp_neg = 1'b1;
      end
      default:        pp = '0;
    endcase
  end

  assign sum          = acc_q + pp + {{(2*W-1){1'b0}}, pp_neg};
  assign mplier_shift = {mplier_q[W], mplier_q[W], mplier_q[W:2]};
  // A uniform remaining multiplier only ever decodes to zero digits.
  assign last_step    = (cnt_q == CW'(N - 1)) ||
                        (EARLY_TERM && ((mplier_shift == '0) || (mplier_shift == '1)));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mul_valid) begin
          state_d  = S_BUSY;
          acc_d    = '0;
          mcand_d  = {{W{ext_a[W-1]}}, ext_a};
          mplier_d = {ext_b, 1'b0};
          cnt_d    = '0;
          word_d   = WORD_OK & bus.mul_word;
        end
      end
      S_BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          state_d = S_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      word_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.mul_ready = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;
endmodule

// File: tb/tb_booth4_mul_unit.sv
// Scoreboard bench for booth4_mul_unit: random and directed requests are
// checked against a plain-multiply reference model by an independent monitor.
module tb_booth4_mul_unit;
  localparam int XLEN = 64;
  localparam int NSTEP = (XLEN + 2) / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth4_mul_if #(.XLEN(XLEN)) bus ();
  booth4_mul_if #(.XLEN(XLEN)) bus_ne ();

  booth4_mul_unit #(.XLEN(XLEN), .WORD_EN(1'b1), .EARLY_TERM(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  booth4_mul_unit #(.XLEN(XLEN), .WORD_EN(1'b1), .EARLY_TERM(1'b0)) dut_ne (
    .clk(clk), .rst(rst), .bus(bus_ne.slave)
  );

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          min_e;
    int          max_e;
    int          acc_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic prev_valid = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_lat(string name, int e, int lo, int hi);
    n_tests++;
    if (e < lo || e > hi) begin
      n_fail++;
      $display("FAIL %s: latency %0d cycles, required %0d..%0d", name, e, lo, hi);
    end
  endfunction

  // Reference: extend both operands, multiply, then slice/sign-extend.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input bit as, input bit bs, input bit w,
                                output logic [63:0] hi, output logic [63:0] lo);
    logic signed [131:0] ea, eb, p;
    if (w) begin
      ea = as ? {{100{a[31]}}, a[31:0]} : {100'b0, a[31:0]};
      eb = bs ? {{100{b[31]}}, b[31:0]} : {100'b0, b[31:0]};
    end else begin
      ea = as ? {{68{a[63]}}, a} : {68'b0, a};
      eb = bs ? {{68{b[63]}}, b} : {68'b0, b};
    end
    p = ea * eb;
    if (w) begin
      lo = {{32{p[31]}}, p[31:0]};
      hi = {{32{p[63]}}, p[63:32]};
    end else begin
      lo = p[63:0];
      hi = p[127:64];
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no result pending");
        end else begin
          chk_lat("latency", cyc - sbq[0].acc_cyc, sbq[0].min_e, sbq[0].max_e);
        end
      end
      if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_hi", bus.result_hi, e.hi);
        chk("result_lo", bus.result_lo, e.lo);
      end
      prev_valid <= bus.out_valid;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input bit as, input bit bs, input bit w,
                       input logic [63:0] ehi, input logic [63:0] elo,
                       input int emin, input int emax);
    exp_t e;
    int guard = 0;
    while (!bus.mul_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        $display("FAIL issue_timeout: mul_ready stayed 0 for %0d cycles", guard);
        $fatal(1, "issue timeout");
      end
    end
    bus.mul_valid    = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.a_signed     = as;
    bus.b_signed     = bs;
    bus.mul_word     = w;
    e.hi = ehi; e.lo = elo; e.min_e = emin; e.max_e = emax; e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    bus.mul_valid    = 1'b0;
    // Garbage after acceptance must not disturb the in-flight operation.
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.a_signed     = 1'($urandom);
    bus.b_signed     = 1'($urandom);
    bus.mul_word     = 1'($urandom);
    chk("mul_ready_after_accept", {63'b0, bus.mul_ready}, 64'd0);
  endtask

  task automatic issue_model(input logic [63:0] a, input logic [63:0] b,
                             input bit as, input bit bs, input bit w);
    logic [63:0] hi, lo;
    model(a, b, as, bs, w, hi, lo);
    issue(a, b, as, bs, w, hi, lo, 1, NSTEP);
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      1:       v[63:8] = '0;
      2:       v[63:8] = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic ne_run(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ehi, input logic [63:0] elo);
    int e = 0;
    @(negedge clk);
    bus_ne.mul_valid    = 1'b1;
    bus_ne.multiplicand = a;
    bus_ne.multiplier   = b;
    @(negedge clk);
    bus_ne.mul_valid = 1'b0;
    while (!bus_ne.out_valid && e < 60) begin
      @(negedge clk);
      e++;
    end
    chk_lat("ne_latency", e, NSTEP, NSTEP);
    chk("ne_result_hi", bus_ne.result_hi, ehi);
    chk("ne_result_lo", bus_ne.result_lo, elo);
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held_hi, held_lo, a_r;
    int guard;
    rst = 1'b1;
    bus.flush = 1'b0; bus.mul_valid = 1'b0; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    bus.mul_word = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    bus_ne.flush = 1'b0; bus_ne.mul_valid = 1'b0; bus_ne.a_signed = 1'b0;
    bus_ne.b_signed = 1'b0; bus_ne.mul_word = 1'b0; bus_ne.multiplicand = '0;
    bus_ne.multiplier = '0; bus_ne.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mul_ready", {63'b0, bus.mul_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_result_hi", bus.result_hi, 64'd0);
    chk("reset_result_lo", bus.result_lo, 64'd0);
    rst = 1'b0;
    rdy_mode = 2;
    @(negedge clk);

    // Directed corner cases.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1, NSTEP);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, NSTEP);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0,
          64'h0, 64'h1, 1, NSTEP);
    issue(64'd3, 64'd5, 0, 0, 0, 64'h0, 64'd15, 1, 2);
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1, 1);
    issue(64'hDEAD_BEEF_7FFF_FFFF, 64'hCAFE_BABE_0000_0002, 1, 1, 1,
          64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1, NSTEP);

    for (int i = 0; i < 150; i++)
      issue_model(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Backpressure: result held while out_ready is low.
    rdy_mode = 0;
    @(negedge clk);
    issue_model(rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_out_valid_rise", {63'b0, bus.out_valid}, 64'd1);
    held_hi = bus.result_hi;
    held_lo = bus.result_lo;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid_held", {63'b0, bus.out_valid}, 64'd1);
      chk("bp_result_hi_held", bus.result_hi, held_hi);
      chk("bp_result_lo_held", bus.result_lo, held_lo);
      chk("bp_mul_ready_low", {63'b0, bus.mul_ready}, 64'd0);
    end
    rdy_mode = 1;
    @(negedge clk);
    chk("bp_mul_ready_in_consume_cycle", {63'b0, bus.mul_ready}, 64'd0);
    @(negedge clk);
    chk("bp_mul_ready_after_consume", {63'b0, bus.mul_ready}, 64'd1);
    chk("bp_out_valid_after_consume", {63'b0, bus.out_valid}, 64'd0);
    rdy_mode = 2;

    // Flush ten cycles into a long operation.
    a_r = {$urandom, $urandom};
    issue(a_r, 64'h5555_5555_5555_5555, 0, 0, 0, 64'h0, 64'h0, 1, NSTEP);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    void'(sbq.pop_back());
    chk("flush_mul_ready", {63'b0, bus.mul_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
    issue(64'd6, 64'd7, 0, 0, 0, 64'h0, 64'd42, 1, NSTEP);
    drain();

    // Flush together with a request in IDLE: nothing accepted.
    bus.mul_valid = 1'b1; bus.flush = 1'b1;
    bus.multiplicand = 64'd9; bus.multiplier = 64'd9;
    @(negedge clk);
    bus.mul_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_idle_mul_ready", {63'b0, bus.mul_ready}, 64'd1);
    repeat (NSTEP + 3) @(negedge clk);
    chk("flush_idle_out_valid", {63'b0, bus.out_valid}, 64'd0);

    // Reset in the middle of an operation.
    issue(a_r, 64'h5555_5555_5555_5555, 0, 0, 0, 64'h0, 64'h0, 1, NSTEP);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mul_ready", {63'b0, bus.mul_ready}, 64'd1);
    chk("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("midrst_result_hi", bus.result_hi, 64'd0);
    chk("midrst_result_lo", bus.result_lo, 64'd0);
    repeat (NSTEP + 3) @(negedge clk);
    chk("midrst_no_output", {63'b0, bus.out_valid}, 64'd0);

    // Without early termination every operation takes the full step count.
    ne_run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
    ne_run(64'd3, 64'd5, 64'h0, 64'd15);

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
